// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver and
// the character controller that consumes its keycode.
package ps2_pkg;

    // Frame deserialiser states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    // Scan-code prefixes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    // Arrow keys (E0-prefixed on the keyboard; stored here without the prefix)
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises the raw PS/2 clock and data lines, removes
// glitches from the clock with a run-length filter and produces a one-cycle
// strobe on each filtered falling clock edge.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall_stb
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic [CW-1:0] run_cnt;
    logic          clk_filt_q;

    // Two-flop synchronisers; idle-high reset matches an undriven PS/2 bus
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            run_cnt  <= '0;
        end else if (clk_s2 == clk_filt) begin
            run_cnt  <= '0;
        end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            run_cnt  <= '0;
        end else begin
            run_cnt  <= run_cnt + CW'(1);
        end
    end

    // Registered falling-edge detect on the filtered clock
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_q <= 1'b1;
            fall_stb   <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt;
            fall_stb   <= clk_filt_q & ~clk_filt;
        end
    end

    assign data_sync = dat_s2;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard receiver. Deframes 11-bit device-to-host
// frames, tracks E0/F0 prefixes and holds the currently pressed key.
// Optional feature macro: PS2_RX_TIMEOUT_EN enables the inter-edge timeout
// that abandons stalled frames with a frame_err pulse.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       keycode_ext,
    output logic       make_stb,
    output logic       frame_err
);

    // Parameters are checked in every build so one set of overrides suits both
    if (FILTER_LEN == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_keycode_rx: FILTER_LEN must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    logic         clk_filt;
    logic         data_sync;
    logic         fall_stb;
    logic         bit_edge;
    logic         timeout;
    logic         byte_ok;

    frame_state_t state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shift;
    logic         par_bit;
    logic         ext;
    logic         brk;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .fall_stb  (fall_stb)
    );

    // The strobe trails the filtered edge by a cycle; requiring the line still
    // low guards against a filtered clock that has already bounced back.
    assign bit_edge = fall_stb & ~clk_filt;

    // Odd parity over data plus parity bit, and a high stop bit
    assign byte_ok  = (^{par_bit, shift}) & data_sync;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    // The edge cycle counts as cycle 1, so expiry registers frame_err exactly
    // TIMEOUT_CYCLES cycles after the last edge strobe.
    assign timeout = (state != ST_IDLE) && !bit_edge &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Cycles elapsed since the last bit edge while a frame is in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (bit_edge) begin
            to_cnt <= TW'(1);
        end else if (state == ST_IDLE || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Frame FSM with prefix tracking and held-key decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            keycode     <= '0;
            keycode_ext <= 1'b0;
            make_stb    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            make_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (bit_edge) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_sync;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!byte_ok) begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end else if (shift == PS2_EXT) begin
                            ext <= 1'b1;
                        end else if (shift == PS2_BRK) begin
                            brk <= 1'b1;
                        end else begin
                            if (!brk) begin
                                keycode     <= shift;
                                keycode_ext <= ext;
                                make_stb    <= 1'b1;
                            end else if (shift == keycode && ext == keycode_ext) begin
                                keycode     <= '0;
                                keycode_ext <= 1'b0;
                            end
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end
        end
    end

endmodule
